// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring mantissa division,
// one quotient bit per cycle, round-to-nearest-even, flush-to-zero, valid/ready on both sides.
module fp_div_seq #(
    parameter logic [31:0] QNAN  = 32'h7FC0_0000,
    parameter int          QBITS = 26
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV   = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    // Exponent zero covers true zeros and flushed subnormals alike.
    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:23] == 8'h00);
    endfunction

    state_t             state_r, state_s;
    logic [31:0]        a_r, b_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [24:0]        rem_r;
    logic [23:0]        d_r;
    logic [25:0]        q_r;
    logic [4:0]         cnt_r;
    logic [31:0]        result_r, result_s;
    logic [4:0]         flags_r, flags_s;
    logic               out_valid_r, out_valid_s;
    logic               in_ready_r, in_ready_s;

    logic               sign_s;
    logic               spec_hit_s;
    logic [31:0]        spec_res_s;
    logic [4:0]         spec_flg_s;
    logic               ge_s;
    logic [23:0]        rem_sub_s;
    logic [24:0]        rem_step_s;
    logic [23:0]        sig_s;
    logic               g_s, st_s, rup_s;
    logic signed [9:0]  exp_a_s, exp_f_s;
    logic [22:0]        frac_f_s;
    logic [31:0]        rnd_res_s;
    logic [4:0]         rnd_flg_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;
    assign sign_s    = a_r[31] ^ b_r[31];

    // Special-operand classification, evaluated on the latched operands during PREP.
    always_comb begin
        spec_hit_s = 1'b1;
        spec_res_s = 32'd0;
        spec_flg_s = 5'd0;
        if (is_nan(a_r) || is_nan(b_r)) begin
            spec_res_s = QNAN;
            spec_flg_s = {(is_nan(a_r) && !a_r[22]) || (is_nan(b_r) && !b_r[22]), 4'b0000};
        end else if ((is_zero(a_r) && is_zero(b_r)) || (is_inf(a_r) && is_inf(b_r))) begin
            spec_res_s = QNAN;
            spec_flg_s = 5'b10000;
        end else if (is_inf(a_r)) begin
            spec_res_s = {sign_s, 8'hFF, 23'd0};
        end else if (is_inf(b_r)) begin
            spec_res_s = {sign_s, 31'd0};
        end else if (is_zero(b_r)) begin
            spec_res_s = {sign_s, 8'hFF, 23'd0};
            spec_flg_s = 5'b01000;
        end else if (is_zero(a_r)) begin
            spec_res_s = {sign_s, 31'd0};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // One restoring-division step; the partial remainder always stays below 2*d, so 25 bits suffice.
    always_comb begin
        ge_s      = (rem_r >= {1'b0, d_r});
        rem_sub_s = rem_r[23:0] - d_r;
        if (ge_s) begin
            rem_step_s = {rem_sub_s, 1'b0};
        end else begin
            rem_step_s = {rem_r[23:0], 1'b0};
        end
    end

    // Normalise the quotient, round to nearest even and detect exponent overflow/underflow.
    always_comb begin
        if (q_r[25]) begin
            sig_s   = q_r[25:2];
            g_s     = q_r[1];
            st_s    = q_r[0] | (rem_r != 25'd0);
            exp_a_s = exp_r;
        end else begin
            sig_s   = q_r[24:1];
            g_s     = q_r[0];
            st_s    = (rem_r != 25'd0);
            exp_a_s = exp_r - 10'sd1;
        end
        rup_s    = g_s && (st_s || sig_s[0]);
        frac_f_s = sig_s[22:0] + {22'd0, rup_s};
        if (rup_s && (&sig_s)) begin
            exp_f_s = exp_a_s + 10'sd1;
        end else begin
            exp_f_s = exp_a_s;
        end
        if (exp_f_s >= 10'sd255) begin
            rnd_res_s = {sign_r, 8'hFF, 23'd0};
            rnd_flg_s = 5'b00101;
        end else if (exp_f_s <= 10'sd0) begin
            rnd_res_s = {sign_r, 31'd0};
            rnd_flg_s = 5'b00011;
        end else begin
            rnd_res_s = {sign_r, exp_f_s[7:0], frac_f_s};
            rnd_flg_s = {4'b0000, g_s | st_s};
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = in_valid ? S_PREP : S_IDLE;
            S_PREP:  state_s = spec_hit_s ? S_DONE : S_DIV;
            S_DIV:   state_s = (cnt_r == CNT_LAST) ? S_ROUND : S_DIV;
            S_ROUND: state_s = S_DONE;
            S_DONE:  state_s = out_ready ? S_IDLE : S_DONE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered handshake and result outputs.
    always_comb begin
        result_s    = result_r;
        flags_s     = flags_r;
        out_valid_s = out_valid_r;
        case (state_r)
            S_PREP: begin
                if (spec_hit_s) begin
                    result_s    = spec_res_s;
                    flags_s     = spec_flg_s;
                    out_valid_s = 1'b1;
                end else begin
                    out_valid_s = 1'b0;
                end
            end
            S_ROUND: begin
                result_s    = rnd_res_s;
                flags_s     = rnd_flg_s;
                out_valid_s = 1'b1;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: out_valid_s = 1'b0;
        endcase
        in_ready_s = (state_s == S_IDLE);
    end

    // Registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            result_r    <= 32'd0;
            flags_r     <= 5'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            result_r    <= result_s;
            flags_r     <= flags_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
        end
    end

    // Operand capture and mantissa-division datapath.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            sign_r <= 1'b0;
            exp_r  <= 10'sd0;
            rem_r  <= 25'd0;
            d_r    <= 24'd0;
            q_r    <= 26'd0;
            cnt_r  <= 5'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r <= dividend;
                        b_r <= divisor;
                    end
                end
                S_PREP: begin
                    sign_r <= sign_s;
                    exp_r  <= $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd127;
                    rem_r  <= {2'b01, a_r[22:0]};
                    d_r    <= {1'b1, b_r[22:0]};
                    q_r    <= 26'd0;
                    cnt_r  <= 5'd0;
                end
                S_DIV: begin
                    rem_r <= rem_step_s;
                    q_r   <= {q_r[24:0], ge_s};
                    cnt_r <= cnt_r + 5'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq: hand-computed quotients, flags and latencies,
// backpressure hold and mid-operation reset.
module tb_fp_div_seq;

    logic        clk;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    int errors = 0;
    int checks = 0;

    fp_div_seq dut (
        .CLK       (clk),
        .nRST      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one operation, check latency, result and flags; leave out_valid asserted.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [4:0] exp_flg, input int exp_lat);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h1234_5678;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_flg"}, {27'd0, flags}, {27'd0, exp_flg});
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ov_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ir_set"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic [4:0] exp_flg, input int exp_lat);
        run(tag, a, b, exp_res, exp_flg, exp_lat);
        release_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        #12;
        chk("rst_ir", {31'd0, in_ready}, 32'd1);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_flg", {27'd0, flags}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        op("six_by_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 28);
        op("one_third",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5'b00001, 28);
        op("neg_norm",    32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 5'b00000, 28);
        op("div0_pos",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 5'b01000, 1);
        op("div0_neg",    32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 5'b01000, 1);
        op("zero_zero",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 5'b10000, 1);
        op("snan",        32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000, 1);
        op("qnan",        32'h7FC0_0001, 32'h4000_0000, 32'h7FC0_0000, 5'b00000, 1);
        op("inf_inf",     32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 5'b10000, 1);
        op("inf_x",       32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 5'b00000, 1);
        op("x_inf",       32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 5'b00000, 1);
        op("zero_x",      32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 5'b00000, 1);
        op("ftz_x",       32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 5'b00000, 1);
        op("overflow",    32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 5'b00101, 28);
        op("underflow",   32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 5'b00011, 28);

        // Backpressure: result held, new requests ignored.
        run("hold", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 28);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 32'h3F80_0000;
            divisor  = 32'h4040_0000;
            @(posedge clk);
            #1;
            chk("hold_res", result, 32'h4040_0000);
            chk("hold_ov", {31'd0, out_valid}, 32'd1);
            chk("hold_ir", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_out("hold");

        // Reset in the middle of the division loop.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'h3F80_0000;
        divisor  = 32'h4040_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_ov", {31'd0, out_valid}, 32'd0);
        chk("midrst_ir", {31'd0, in_ready}, 32'd1);
        chk("midrst_res", result, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        op("after_rst", 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 5'b00000, 28);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
